// File: rtl/shift_add_mul_seq.sv
// ---------------------------------------------------------------------------
// shift_add_mul_seq
//   Multi-cycle unsigned multiplier for the execute-stage MUL path. One
//   WIDTH-bit ripple-carry adder is reused over WIDTH shift-add steps, one
//   multiplier bit per clock. The pipeline stalls while busy is high.
//
//   Optional feature macro: MUL_EARLY_TERM_EN
//     When defined, an operation finishes as soon as all remaining multiplier
//     bits are zero (latency 1..WIDTH, bit-identical result). When undefined,
//     every operation takes exactly WIDTH RUN cycles.
//
// Parameters
//   WIDTH    operand width (2..64); product is 2*WIDTH bits
//
// Ports
//   clk      clock, all state updates on the rising edge
//   rst      asynchronous, active-high reset
//   start    request; only looked at in IDLE or DONE
//   flush    synchronous cancel; beats start and completion
//   a        multiplicand, captured when start is accepted
//   b        multiplier, captured when start is accepted
//   busy     high while an operation is running
//   done     one-cycle completion pulse
//   product  registered result, held until the next completion
// ---------------------------------------------------------------------------
module shift_add_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     add_sum;
    logic                 add_carry;
    logic                 accept;
    logic                 rem_zero;
    logic [2*WIDTH-1:0]   acc_step;

    // A new operation is taken only from IDLE or DONE, and never when flushed.
    assign accept = start & ~flush & ((state_q == ST_IDLE) | (state_q == ST_DONE));

    // Ripple-carry adder built from WIDTH full-adder cells:
    // {add_carry, add_sum} = acc_hi + (acc_q[0] ? mcand : 0), carry-in 0.
    always_comb begin : ripple_adder
        logic c;
        logic x;
        logic y;
        c       = 1'b0;
        x       = 1'b0;
        y       = 1'b0;
        add_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            x          = acc_q[WIDTH + i];
            y          = mcand_q[i] & acc_q[0];
            add_sum[i] = x ^ y ^ c;
            c          = (x & y) | (c & (x ^ y));
        end
        add_carry = c;
    end

    // Shift the sum in from the top; the consumed multiplier bit falls off
    // the bottom. The adder carry becomes the new MSB.
    assign acc_step = {add_carry, add_sum, acc_q[WIDTH-1:1]};

    // Early termination: the unprocessed multiplier bits are acc_q[cnt_q-1:0].
    always_comb begin
        rem_zero = 1'b0;
`ifdef MUL_EARLY_TERM_EN
        rem_zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i < int'(cnt_q)) && acc_q[i]) begin
                rem_zero = 1'b0;
            end
        end
`endif
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flush)                              state_d = ST_IDLE;
                else if (rem_zero || (cnt_q == CNT_W'(1))) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = accept ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (accept) begin
            acc_d   = {{WIDTH{1'b0}}, b};
            mcand_d = a;
            cnt_d   = CNT_W'(WIDTH);
        end else if ((state_q == ST_RUN) && !flush) begin
            if (rem_zero) begin
                // Remaining multiplier bits are zero: the partial product
                // already sits in the upper bits, just align it.
                product_d = acc_q >> cnt_q;
            end else begin
                acc_d = acc_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    product_d = acc_step;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Outputs
    always_comb begin
        busy    = (state_q == ST_RUN);
        done    = (state_q == ST_DONE);
        product = product_q;
    end

endmodule

// File: tb/tb_shift_add_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_add_mul_seq
//   Self-checking bench for shift_add_mul_seq. Runs a WIDTH=8 instance
//   through directed cases and randomized traffic, and a WIDTH=32 instance
//   with randomized traffic in parallel. Expected products come from plain
//   multiplication, expected latency from the multiplier bit pattern.
// ---------------------------------------------------------------------------
module tb_shift_add_mul_seq;

    localparam int W  = 8;
    localparam int W2 = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, flush;
    logic [W-1:0]      a, b;
    logic              busy, done;
    logic [2*W-1:0]    product;

    logic              rst32, start32, flush32;
    logic [W2-1:0]     a32, b32;
    logic              busy32, done32;
    logic [2*W2-1:0]   product32;

    int n_chk = 0;
    int n_err = 0;

    logic [2*W-1:0]  ref_prod;
    logic [2*W2-1:0] ref_prod32;

    shift_add_mul_seq #(.WIDTH(W)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .a(a), .b(b), .busy(busy), .done(done), .product(product)
    );

    shift_add_mul_seq #(.WIDTH(W2)) u_dut32 (
        .clk(clk), .rst(rst32), .start(start32), .flush(flush32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .product(product32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Number of RUN cycles an operation should take for multiplier bv.
    function automatic int exp_edges(input logic [63:0] bv, input int w);
`ifdef MUL_EARLY_TERM_EN
        int msb;
        msb = -1;
        for (int i = 0; i < w; i++) if (bv[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + 2 < w) ? msb + 2 : w;
`else
        return w;
`endif
    endfunction

    // Waits (bounded) for done on the 8-bit DUT; counts busy cycles seen first.
    task automatic wait_done8(output int cyc, output bit seen, input bit junk);
        cyc  = 0;
        seen = 0;
        for (int i = 0; i < W + 4 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                if (junk) start = 1'b0;
            end else begin
                if (busy) cyc++;
                if (junk) begin
                    start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
                    a = W'($urandom);
                    b = W'($urandom);
                end
            end
        end
    endtask

    // One operation on the 8-bit DUT. fk>0: flush sampled at RUN edge fk.
    task automatic op8(input logic [W-1:0] ai, input logic [W-1:0] bi, input int fk, input bit junk);
        int cyc;
        int nd;
        bit seen;
        start = 1'b1; flush = 1'b0; a = ai; b = bi;
        @(posedge clk); #1;
        start = 1'b0;
        if (junk) begin a = W'($urandom); b = W'($urandom); end
        if (fk > 0) begin
            repeat (fk - 1) @(posedge clk);
            #1 flush = 1'b1;
            @(posedge clk); #1 flush = 1'b0;
            @(negedge clk);
            check("flush8_busy", busy, 0);
            check("flush8_done", done, 0);
            check("flush8_prod", product, ref_prod);
            nd = 0;
            repeat (W + 2) begin
                @(negedge clk);
                if (done) nd++;
            end
            check("flush8_nodone", nd, 0);
        end else begin
            wait_done8(cyc, seen, junk);
            ref_prod = {{W{1'b0}}, ai} * {{W{1'b0}}, bi};
            check("op8_seen", seen, 1);
            check("op8_lat", cyc, exp_edges(bi, W));
            check("op8_prod", product, ref_prod);
            @(negedge clk);
            check("op8_pulse", {busy, done}, 2'b00);
        end
    endtask

    // One operation on the 32-bit DUT, same protocol as op8.
    task automatic op32(input logic [W2-1:0] ai, input logic [W2-1:0] bi, input int fk);
        int cyc;
        int nd;
        bit seen;
        start32 = 1'b1; flush32 = 1'b0; a32 = ai; b32 = bi;
        @(posedge clk); #1;
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom;
        if (fk > 0) begin
            repeat (fk - 1) @(posedge clk);
            #1 flush32 = 1'b1;
            @(posedge clk); #1 flush32 = 1'b0;
            @(negedge clk);
            check("flush32_state", {busy32, done32}, 2'b00);
            check("flush32_prod", product32, ref_prod32);
            nd = 0;
            repeat (W2 + 2) begin
                @(negedge clk);
                if (done32) nd++;
            end
            check("flush32_nodone", nd, 0);
        end else begin
            cyc = 0; seen = 0;
            for (int i = 0; i < W2 + 4 && !seen; i++) begin
                @(negedge clk);
                if (done32) begin
                    seen = 1;
                    start32 = 1'b0;
                end else begin
                    if (busy32) cyc++;
                    start32 = busy32 ? 1'($urandom_range(0, 1)) : 1'b0;
                    a32 = $urandom; b32 = $urandom;
                end
            end
            ref_prod32 = {{W2{1'b0}}, ai} * {{W2{1'b0}}, bi};
            check("op32_seen", seen, 1);
            check("op32_lat", cyc, exp_edges(64'(bi), W2));
            check("op32_prod", product32, ref_prod32);
            @(negedge clk);
            check("op32_pulse", {busy32, done32}, 2'b00);
        end
    endtask

    initial begin
        int  cyc;
        int  nd;
        bit  seen;
        logic [W-1:0]  ra, rb;
        logic [W2-1:0] ra32, rb32;

        rst = 1'b1; start = 1'b0; flush = 1'b0; a = '0; b = '0;
        rst32 = 1'b1; start32 = 1'b0; flush32 = 1'b0; a32 = '0; b32 = '0;
        ref_prod = '0; ref_prod32 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; rst32 = 1'b0;
        @(negedge clk);
        check("rst8_state", {busy, done}, 2'b00);
        check("rst8_prod", product, 0);
        check("rst32_state", {busy32, done32}, 2'b00);
        check("rst32_prod", product32, 0);

        fork
            begin : dut8_thread
                // Directed cases
                op8(8'd5, 8'd3, 0, 0);
                op8(8'hFF, 8'hFF, 0, 0);
                op8(8'h00, 8'hA5, 0, 0);
                op8(8'h37, 8'h00, 0, 0);

                // Back-to-back: start held, new operands offered while busy
                start = 1'b1; a = 8'd12; b = 8'd10;
                @(posedge clk); #1;
                a = 8'd7; b = 8'd9;
                wait_done8(cyc, seen, 0);
                check("b2b1_seen", seen, 1);
                check("b2b1_lat", cyc, exp_edges(64'd10, W));
                check("b2b1_prod", product, 120);
                @(posedge clk); #1;
                start = 1'b0; a = 8'hEE; b = 8'hEE;
                @(negedge clk);
                check("b2b_no_idle", busy, 1);
                wait_done8(cyc, seen, 0);
                check("b2b2_seen", seen, 1);
                check("b2b2_lat", cyc + 1, exp_edges(64'd9, W));
                check("b2b2_prod", product, 63);
                ref_prod = 16'd63;
                @(negedge clk);
                check("b2b2_pulse", {busy, done}, 2'b00);

                // Flush during RUN, sampled on the fourth RUN edge
                op8(8'd3, 8'd4, 4, 0);

                // Flush together with start in IDLE: not accepted
                start = 1'b1; flush = 1'b1; a = 8'd9; b = 8'd9;
                @(posedge clk); #1;
                start = 1'b0; flush = 1'b0;
                nd = 0;
                repeat (W + 3) begin
                    @(negedge clk);
                    if (busy || done) nd++;
                end
                check("fs_idle_ignored", nd, 0);
                check("fs_idle_prod", product, ref_prod);

                // Asynchronous reset in the middle of RUN
                start = 1'b1; a = 8'd200; b = 8'd201;
                @(posedge clk); #1;
                start = 1'b0;
                repeat (3) @(posedge clk);
                #2 rst = 1'b1;
                #1;
                check("rst_mid_state", {busy, done}, 2'b00);
                check("rst_mid_prod", product, 0);
                ref_prod = '0;
                @(posedge clk); #1 rst = 1'b0;
                nd = 0;
                repeat (W + 2) begin
                    @(negedge clk);
                    if (done) nd++;
                end
                check("rst_mid_nodone", nd, 0);
                op8(8'd5, 8'd6, 0, 0);

                // Randomized traffic
                for (int n = 0; n < 1200; n++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    ra = W'($urandom);
                    rb = ($urandom_range(0, 3) == 0) ? W'($urandom & 32'h0F) : W'($urandom);
                    if ($urandom_range(0, 6) == 0)
                        op8(ra, rb, $urandom_range(1, exp_edges(64'(rb), W)), 0);
                    else
                        op8(ra, rb, 0, 1);
                end
            end
            begin : dut32_thread
                for (int n = 0; n < 280; n++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    ra32 = $urandom;
                    rb32 = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_FFFF) : $urandom;
                    if ($urandom_range(0, 6) == 0)
                        op32(ra32, rb32, $urandom_range(1, exp_edges(64'(rb32), W2)));
                    else
                        op32(ra32, rb32, 0);
                end
            end
        join

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
